// File: rtl/int_writeback_stage_pkg.sv
// PipelineTypes: shared types for the integer writeback stage.
// Holds the per-lane register-path struct and the recovery FSM encoding.
package PipelineTypes;

  localparam int INT_ISSUE_WIDTH = 2;
  localparam int DATA_WIDTH      = 32;
  localparam int PREG_IDX_W      = 6;
  localparam int PC_W            = 32;

  // One lane of the execute->writeback pipeline register.
  typedef struct packed {
    logic                  valid;
    logic                  dataValid;
    logic [DATA_WIDTH-1:0] data;
    logic [PREG_IDX_W-1:0] dstReg;
    logic                  writeReg;
    logic                  brValid;
    logic                  brMispred;
    logic [PC_W-1:0]       brNextAddr;
  } IntegerWritebackRegPath;

  typedef enum logic [1:0] {
    REC_IDLE = 2'd0,
    REC_REQ  = 2'd1,
    REC_WAIT = 2'd2
  } RecoveryState;

endpackage

// File: rtl/int_writeback_stage_age_sel.sv
// AlAgeSelector: picks the oldest mispredict candidate relative to the
// active-list head. Age wraps modulo 2^AL_PTR_W; ties go to the lowest lane.
module AlAgeSelector #(
  parameter int W        = 2,
  parameter int AL_PTR_W = 6,
  parameter int IDX_W    = 1
) (
  input  logic [W-1:0]               cand,
  input  logic [W-1:0][AL_PTR_W-1:0] ptr,
  input  logic [AL_PTR_W-1:0]        headPtr,
  output logic                       anyValid,
  output logic [IDX_W-1:0]           selLane,
  output logic [AL_PTR_W-1:0]        selPtr,
  output logic [AL_PTR_W-1:0]        selAge
);

  logic [AL_PTR_W-1:0] age;

  // Ascending scan with strict less-than keeps the lowest lane on ties.
  always_comb begin
    anyValid = 1'b0;
    selLane  = '0;
    selPtr   = '0;
    selAge   = '0;
    age      = '0;
    for (int i = 0; i < W; i++) begin
      age = ptr[i] - headPtr;
      if (cand[i] && (!anyValid || age < selAge)) begin
        anyValid = 1'b1;
        selLane  = IDX_W'(i);
        selPtr   = ptr[i];
        selAge   = age;
      end
    end
  end

endmodule

// File: rtl/int_writeback_stage.sv
// int_writeback_stage: integer writeback pipeline register, register-file
// write and active-list finish reporting, and branch-mispredict recovery
// request FSM.
// Optional: define RSD_INT_WB_PERF_COUNTER_EN to add saturating perf counters
// (perfWrites, perfMispred).
//
//   state    | meaning
//   REC_IDLE | no recovery outstanding; accepts the oldest candidate
//   REC_REQ  | recReq asserted; a strictly older candidate replaces the held one
//   REC_WAIT | acknowledged, waiting for recDone; new candidates ignored
module int_writeback_stage
  import PipelineTypes::*;
#(
  parameter int W        = INT_ISSUE_WIDTH,
  parameter int AL_PTR_W = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         clear,
  input  logic [W-1:0]                 exValid,
  // Bit DATA_WIDTH of each lane is the data-valid flag.
  input  logic [W-1:0][DATA_WIDTH:0]   exData,
  input  logic [W-1:0][PREG_IDX_W-1:0] exDstReg,
  input  logic [W-1:0]                 exWriteReg,
  input  logic [W-1:0][AL_PTR_W-1:0]   exAlPtr,
  input  logic [W-1:0]                 exBrValid,
  input  logic [W-1:0]                 exBrMispred,
  input  logic [W-1:0][PC_W-1:0]       exBrNextAddr,
  input  logic [W-1:0]                 flush,
  input  logic [AL_PTR_W-1:0]          alHeadPtr,
  output logic [W-1:0]                 regWe,
  output logic [W-1:0][PREG_IDX_W-1:0] regWAddr,
  output logic [W-1:0][DATA_WIDTH-1:0] regWData,
  output logic [W-1:0]                 alFinValid,
  output logic [W-1:0][AL_PTR_W-1:0]   alFinPtr,
  output logic [W-1:0]                 alFinReplay,
  output logic                         recReq,
  output logic [AL_PTR_W-1:0]          recPtr,
  output logic [PC_W-1:0]              recAddr,
  input  logic                         recAck,
  input  logic                         recDone
`ifdef RSD_INT_WB_PERF_COUNTER_EN
  ,
  output logic [31:0]                  perfWrites,
  output logic [31:0]                  perfMispred
`endif
);

  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  IntegerWritebackRegPath [W-1:0]   regPath;
  logic [W-1:0][AL_PTR_W-1:0]       regAlPtr;
  logic [W-1:0]                     laneLive;
  logic [W-1:0]                     cand;
  logic                             selValid;
  logic [IDX_W-1:0]                 selLane;
  logic [AL_PTR_W-1:0]              selPtr;
  logic [AL_PTR_W-1:0]              selAge;
  logic [PC_W-1:0]                  selAddr;
  logic [AL_PTR_W-1:0]              heldAge;
  RecoveryState                     state;

  // Pipeline register: captures the execute outputs unless stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regPath  <= '0;
      regAlPtr <= '0;
    end else if (!stall) begin
      for (int i = 0; i < W; i++) begin
        regPath[i].valid      <= exValid[i];
        regPath[i].dataValid  <= exData[i][DATA_WIDTH];
        regPath[i].data       <= exData[i][DATA_WIDTH-1:0];
        regPath[i].dstReg     <= exDstReg[i];
        regPath[i].writeReg   <= exWriteReg[i];
        regPath[i].brValid    <= exBrValid[i];
        regPath[i].brMispred  <= exBrMispred[i];
        regPath[i].brNextAddr <= exBrNextAddr[i];
        regAlPtr[i]           <= exAlPtr[i];
      end
    end
  end

  // Lane qualification. Stall gates every side effect (writes, finishes and
  // mispredict candidates) so a held op acts exactly once, on release.
  always_comb begin
    laneLive    = '0;
    regWe       = '0;
    regWAddr    = '0;
    regWData    = '0;
    alFinValid  = '0;
    alFinPtr    = '0;
    alFinReplay = '0;
    cand        = '0;
    for (int i = 0; i < W; i++) begin
      laneLive[i]    = regPath[i].valid && !flush[i] && !clear;
      regWe[i]       = laneLive[i] && regPath[i].writeReg && regPath[i].dataValid && !stall;
      regWAddr[i]    = regPath[i].dstReg;
      regWData[i]    = regPath[i].data;
      alFinValid[i]  = laneLive[i] && !stall;
      alFinPtr[i]    = regAlPtr[i];
      alFinReplay[i] = !regPath[i].dataValid;
      cand[i]        = laneLive[i] && regPath[i].brValid && regPath[i].brMispred
                       && regPath[i].dataValid && !stall;
    end
  end

  AlAgeSelector #(
    .W        (W),
    .AL_PTR_W (AL_PTR_W),
    .IDX_W    (IDX_W)
  ) u_ageSel (
    .cand     (cand),
    .ptr      (regAlPtr),
    .headPtr  (alHeadPtr),
    .anyValid (selValid),
    .selLane  (selLane),
    .selPtr   (selPtr),
    .selAge   (selAge)
  );

  assign selAddr = regPath[selLane].brNextAddr;
  assign heldAge = recPtr - alHeadPtr;
  assign recReq  = (state == REC_REQ);

  // Recovery FSM. A replacement taken in the same cycle as recAck is latched,
  // so the value held through WAIT is the one that was acknowledged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= REC_IDLE;
      recPtr  <= '0;
      recAddr <= '0;
    end else begin
      case (state)
        REC_IDLE: if (selValid) begin
          state   <= REC_REQ;
          recPtr  <= selPtr;
          recAddr <= selAddr;
        end
        REC_REQ: begin
          if (selValid && (selAge < heldAge)) begin
            recPtr  <= selPtr;
            recAddr <= selAddr;
          end
          if (recAck) state <= REC_WAIT;
        end
        REC_WAIT: if (recDone) state <= REC_IDLE;
        default: state <= REC_IDLE;
      endcase
    end
  end

`ifdef RSD_INT_WB_PERF_COUNTER_EN
  logic [31:0] writeInc;
  logic [32:0] writeSum;

  // Lanes written this cycle.
  always_comb begin
    writeInc = '0;
    for (int i = 0; i < W; i++) writeInc = writeInc + 32'(regWe[i]);
    writeSum = {1'b0, perfWrites} + {1'b0, writeInc};
  end

  // Saturating counters for lane-writes and acknowledged recovery requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perfWrites  <= '0;
      perfMispred <= '0;
    end else begin
      perfWrites <= writeSum[32] ? '1 : writeSum[31:0];
      if (recReq && recAck && (perfMispred != '1)) perfMispred <= perfMispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_int_writeback_stage.sv
// Directed bench for int_writeback_stage: a vector table for the writeback
// path plus hand sequences for stall, age selection and the recovery FSM.
module tb_int_writeback_stage;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall, clear;
  logic [1:0]        exValid;
  logic [1:0][32:0]  exData;
  logic [1:0][5:0]   exDstReg;
  logic [1:0]        exWriteReg;
  logic [1:0][5:0]   exAlPtr;
  logic [1:0]        exBrValid, exBrMispred;
  logic [1:0][31:0]  exBrNextAddr;
  logic [1:0]        flush;
  logic [5:0]        alHeadPtr;
  logic [1:0]        regWe;
  logic [1:0][5:0]   regWAddr;
  logic [1:0][31:0]  regWData;
  logic [1:0]        alFinValid;
  logic [1:0][5:0]   alFinPtr;
  logic [1:0]        alFinReplay;
  logic              recReq;
  logic [5:0]        recPtr;
  logic [31:0]       recAddr;
  logic              recAck, recDone;
`ifdef RSD_INT_WB_PERF_COUNTER_EN
  logic [31:0]       perfWrites, perfMispred;
`endif

  int nTests = 0;
  int nFail  = 0;

  int_writeback_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .clear        (clear),
    .exValid      (exValid),
    .exData       (exData),
    .exDstReg     (exDstReg),
    .exWriteReg   (exWriteReg),
    .exAlPtr      (exAlPtr),
    .exBrValid    (exBrValid),
    .exBrMispred  (exBrMispred),
    .exBrNextAddr (exBrNextAddr),
    .flush        (flush),
    .alHeadPtr    (alHeadPtr),
    .regWe        (regWe),
    .regWAddr     (regWAddr),
    .regWData     (regWData),
    .alFinValid   (alFinValid),
    .alFinPtr     (alFinPtr),
    .alFinReplay  (alFinReplay),
    .recReq       (recReq),
    .recPtr       (recPtr),
    .recAddr      (recAddr),
    .recAck       (recAck),
    .recDone      (recDone)
`ifdef RSD_INT_WB_PERF_COUNTER_EN
    ,
    .perfWrites   (perfWrites),
    .perfMispred  (perfMispred)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v, dv, wr, fl;
    logic        clr;
    logic [5:0]  dst0, dst1;
    logic [31:0] d0, d1;
    logic [1:0]  eWe, eFin, eRep;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setLane(input int i, input logic v, input logic dv, input logic wr,
                         input logic [5:0] dst, input logic [31:0] d, input logic br,
                         input logic mp, input logic [5:0] ptr, input logic [31:0] addr);
    exValid[i]      = v;
    exData[i]       = {dv, d};
    exDstReg[i]     = dst;
    exWriteReg[i]   = wr;
    exBrValid[i]    = br;
    exBrMispred[i]  = mp;
    exAlPtr[i]      = ptr;
    exBrNextAddr[i] = addr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load the driven ops into the stage register, then stop offering new ones.
  task automatic capture();
    @(posedge clk);
    #1;
    exValid = '0;
  endtask

  task automatic mispred(input int lane, input logic [5:0] ptr, input logic [31:0] addr);
    exValid = '0;
    setLane(lane, 1'b1, 1'b1, 1'b0, 6'd0, 32'd0, 1'b1, 1'b1, ptr, addr);
  endtask

  initial begin
    vecs[0] = '{2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 6'd5, 6'd0, 32'h1234, 32'h0,    2'b01, 2'b01, 2'b10};
    vecs[1] = '{2'b11, 2'b01, 2'b11, 2'b00, 1'b0, 6'd7, 6'd9, 32'hAAAA, 32'h5555, 2'b01, 2'b11, 2'b10};
    vecs[2] = '{2'b11, 2'b11, 2'b11, 2'b00, 1'b0, 6'd3, 6'd4, 32'h11,   32'h22,   2'b11, 2'b11, 2'b00};
    vecs[3] = '{2'b11, 2'b11, 2'b11, 2'b10, 1'b0, 6'd3, 6'd4, 32'h11,   32'h22,   2'b01, 2'b01, 2'b00};
    vecs[4] = '{2'b11, 2'b11, 2'b11, 2'b00, 1'b1, 6'd3, 6'd4, 32'h11,   32'h22,   2'b00, 2'b00, 2'b00};
    vecs[5] = '{2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 6'd8, 6'd9, 32'h33,   32'h44,   2'b00, 2'b11, 2'b00};
    vecs[6] = '{2'b00, 2'b11, 2'b11, 2'b00, 1'b0, 6'd1, 6'd2, 32'h55,   32'h66,   2'b00, 2'b00, 2'b00};
    vecs[7] = '{2'b10, 2'b11, 2'b11, 2'b01, 1'b0, 6'd1, 6'd2, 32'h77,   32'h88,   2'b10, 2'b10, 2'b00};

    rst = 1'b0; stall = 1'b0; clear = 1'b0; flush = '0; alHeadPtr = '0;
    recAck = 1'b0; recDone = 1'b0;
    exValid = '0; exData = '0; exDstReg = '0; exWriteReg = '0; exAlPtr = '0;
    exBrValid = '0; exBrMispred = '0; exBrNextAddr = '0;
    #2;
    check("rst_regWe",      32'(regWe), 32'd0);
    check("rst_alFinValid", 32'(alFinValid), 32'd0);
    check("rst_recReq",     32'(recReq), 32'd0);
    check("rst_recPtr",     32'(recPtr), 32'd0);
    check("rst_recAddr",    recAddr, 32'd0);
    #10 rst = 1'b1;

    // Writeback path vectors.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 2; i++)
        setLane(i, vecs[k].v[i], vecs[k].dv[i], vecs[k].wr[i],
                (i == 0) ? vecs[k].dst0 : vecs[k].dst1,
                (i == 0) ? vecs[k].d0 : vecs[k].d1, 1'b0, 1'b0, 6'd0, 32'd0);
      capture();
      flush = vecs[k].fl;
      clear = vecs[k].clr;
      #1;
      check($sformatf("vec%0d_regWe", k),  32'(regWe), 32'(vecs[k].eWe));
      check($sformatf("vec%0d_fin", k),    32'(alFinValid), 32'(vecs[k].eFin));
      check($sformatf("vec%0d_replay", k), 32'(alFinReplay), 32'(vecs[k].eRep));
      check($sformatf("vec%0d_waddr0", k), 32'(regWAddr[0]), 32'(vecs[k].dst0));
      check($sformatf("vec%0d_wdata0", k), regWData[0], vecs[k].d0);
      check($sformatf("vec%0d_waddr1", k), 32'(regWAddr[1]), 32'(vecs[k].dst1));
      check($sformatf("vec%0d_wdata1", k), regWData[1], vecs[k].d1);
      flush = '0;
      clear = 1'b0;
    end

    // Stall holds the register and suppresses repeated writes.
    exValid = '0;
    setLane(0, 1'b1, 1'b1, 1'b1, 6'd12, 32'hBEEF, 1'b0, 1'b0, 6'd0, 32'd0);
    @(posedge clk); #1;
    stall = 1'b1;
    setLane(0, 1'b1, 1'b1, 1'b1, 6'd13, 32'hCAFE, 1'b0, 1'b0, 6'd0, 32'd0);
    #1;
    check("stall_regWe",  32'(regWe), 32'd0);
    check("stall_fin",    32'(alFinValid), 32'd0);
    check("stall_waddr",  32'(regWAddr[0]), 32'd12);
    tick();
    check("stall_hold",   regWData[0], 32'hBEEF);
    stall = 1'b0;
    #1;
    check("stall_release_we", 32'(regWe), 32'd1);
    exValid = '0;
    tick();
    check("no_repeat_we", 32'(regWe), 32'd0);

    // Wrap-around age: head 60, ptr 61 (age 1) beats ptr 2 (age 6).
    alHeadPtr = 6'd60;
    exValid = '0;
    setLane(0, 1'b1, 1'b1, 1'b0, 6'd0, 32'd0, 1'b1, 1'b1, 6'd2,  32'h100);
    setLane(1, 1'b1, 1'b1, 1'b0, 6'd0, 32'd0, 1'b1, 1'b1, 6'd61, 32'h200);
    capture();
    check("idle_before_req", 32'(recReq), 32'd0);
    tick();
    check("wrap_recReq",  32'(recReq), 32'd1);
    check("wrap_recPtr",  32'(recPtr), 32'd61);
    check("wrap_recAddr", recAddr, 32'h200);

    // Reset in the middle of a request.
    #2 rst = 1'b0;
    #1;
    check("midrst_recReq", 32'(recReq), 32'd0);
    check("midrst_recPtr", 32'(recPtr), 32'd0);
    rst = 1'b1;
    tick();
    check("midrst_idle", 32'(recReq), 32'd0);

    // Replacement by strictly older candidates only.
    alHeadPtr = 6'd0;
    mispred(0, 6'd10, 32'hA0);
    capture(); tick();
    check("post_rst_req", 32'(recReq), 32'd1);
    check("req_ptr10",    32'(recPtr), 32'd10);
    mispred(0, 6'd12, 32'hC0);
    capture(); tick();
    check("younger_ignored", 32'(recPtr), 32'd10);
    mispred(1, 6'd4, 32'h40);
    capture(); tick();
    check("older_ptr",    32'(recPtr), 32'd4);
    check("older_addr",   recAddr, 32'h40);
    check("older_recReq", 32'(recReq), 32'd1);

    // Ack, ignore candidates in WAIT, then done.
    recAck = 1'b1; tick(); recAck = 1'b0;
    check("wait_recReq", 32'(recReq), 32'd0);
    check("wait_ptr",    32'(recPtr), 32'd4);
    mispred(0, 6'd1, 32'h11);
    capture();
    check("wait_alfin",  32'(alFinValid), 32'd1);
    tick();
    check("wait_ignore", 32'(recReq), 32'd0);
    recDone = 1'b1; tick(); recDone = 1'b0;
    check("done_recReq", 32'(recReq), 32'd0);
    mispred(0, 6'd20, 32'h20);
    capture(); tick();
    check("idle_again_req", 32'(recReq), 32'd1);
    check("idle_again_ptr", 32'(recPtr), 32'd20);

    // Same-cycle ack takes the replacement value.
    mispred(0, 6'd3, 32'h33);
    capture();
    recAck = 1'b1; tick(); recAck = 1'b0;
    check("ackrepl_recReq", 32'(recReq), 32'd0);
    check("ackrepl_ptr",    32'(recPtr), 32'd3);
    check("ackrepl_addr",   recAddr, 32'h33);
    recDone = 1'b1; tick(); recDone = 1'b0;

    // Clear suppresses a candidate but does not abort a request.
    mispred(0, 6'd5, 32'h55);
    capture();
    clear = 1'b1;
    #1;
    check("clear_fin", 32'(alFinValid), 32'd0);
    tick();
    clear = 1'b0;
    check("clear_blocks", 32'(recReq), 32'd0);
    mispred(0, 6'd6, 32'h66);
    capture(); tick();
    check("clear_pre_req", 32'(recReq), 32'd1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_no_abort", 32'(recReq), 32'd1);
    check("clear_hold_ptr", 32'(recPtr), 32'd6);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/int_writeback_stage.md
INT_WRITEBACK_STAGE -- requirements
Module: int_writeback_stage

Interface
REQ-001 SHALL have parameter W, default INT_ISSUE_WIDTH (2): number of integer lanes.
REQ-002 SHALL have parameter AL_PTR_W, default 6: active-list pointer width (wraps modulo 2^AL_PTR_W).
REQ-003 SHALL have ports clk, in, 1: clock; rst, in, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports stall, in, 1: backEnd stall; clear, in, 1: backEnd clear.
REQ-005 SHALL have port exValid, in, W: per-lane valid from IntegerExecutionStage.
REQ-006 SHALL have ports exData, in, W x (DATA_WIDTH+1): dataOut plus its valid bit; exDstReg, in, W x PREG_IDX_W; exWriteReg, in, W.
REQ-007 SHALL have ports exAlPtr, in, W x AL_PTR_W; exBrValid, in, W; exBrMispred, in, W; exBrNextAddr, in, W x PC_W.
REQ-008 SHALL have ports flush, in, W: selective flush of the registered op; alHeadPtr, in, AL_PTR_W.
REQ-009 SHALL have ports regWe, out, W; regWAddr, out, W x PREG_IDX_W; regWData, out, W x DATA_WIDTH.
REQ-010 SHALL have ports alFinValid, out, W; alFinPtr, out, W x AL_PTR_W; alFinReplay, out, W.
REQ-011 SHALL have ports recReq, out, 1; recPtr, out, AL_PTR_W; recAddr, out, PC_W; recAck, in, 1; recDone, in, 1.

Function
REQ-012 SHALL capture all ex* inputs into a per-lane pipeline register on clk when stall=0; the register SHALL hold when stall=1.
REQ-013 SHALL define lane-live(i) = reg.valid(i) && !flush(i) && !clear.
REQ-014 SHALL drive regWe(i) = lane-live(i) && writeReg(i) && data.valid(i), with regWAddr/regWData taken from the register; 1-cycle latency from capture.
REQ-015 SHALL drive alFinValid(i) = lane-live(i) and alFinReplay(i) = !data.valid(i); a replayed op SHALL NOT write the register file.
REQ-016 SHALL treat lane i as a mispredict candidate when lane-live(i) && brValid(i) && brMispred(i) && data.valid(i).
REQ-017 SHALL pick, among same-cycle candidates, the oldest by age = (alPtr - alHeadPtr) mod 2^AL_PTR_W; ties by lowest lane.
REQ-018 SHALL implement FSM IDLE/REQ/WAIT: IDLE->REQ on a candidate; REQ->WAIT when recAck=1; WAIT->IDLE when recDone=1.
REQ-019 SHALL assert recReq only in REQ, holding recPtr/recAddr stable except per REQ-020.
REQ-020 SHALL, in REQ, replace the held request with a new candidate strictly older than it; same-cycle recAck SHALL acknowledge the replacement value.
REQ-021 SHALL ignore candidates in WAIT; they are still reported via alFin*.
REQ-022 SHALL, with stall=1, keep outputs driven from the held register but suppress regWe and alFinValid so no write repeats.
REQ-023 SHALL give clear priority over new candidates; clear SHALL NOT abort REQ/WAIT.

Reset
REQ-024 SHALL, on rst=0, asynchronously clear every reg.valid, set FSM to IDLE, and drive recReq, regWe, alFinValid to 0 and recPtr/recAddr to 0.
REQ-025 SHALL, on reset asserted mid-REQ, drop the pending request without requiring recAck.

Configuration
REQ-026 SHALL, with RSD_INT_WB_PERF_COUNTER_EN defined, keep 32-bit saturating counters of regWe lane-writes and accepted mispredict requests, readable via outputs perfWrites/perfMispred (32, out).
REQ-027 SHALL, without the macro, omit the counters and ports entirely.

Structure
REQ-028 SHALL place the register-path struct (IntegerWritebackRegPath) and FSM enum in the shared PipelineTypes package.
REQ-029 SHALL use one sub-module, AlAgeSelector, for the oldest-candidate comparison.

Verification
REQ-030 Lane0 valid, writeReg=1, data=0x1234 valid, dst=5 -> next cycle regWe[0]=1, regWAddr=5, regWData=0x1234, alFinValid[0]=1.
REQ-031 Lane1 data.valid=0 -> alFinReplay[1]=1, regWe[1]=0.
REQ-032 Head=60, lane0 mispred ptr=2, lane1 mispred ptr=61 -> recReq=1, recPtr=61 (wrap-around age).
REQ-033 In REQ with recPtr=10 (head=0), new candidate ptr=4 -> recPtr=4; candidate ptr=12 -> unchanged.
REQ-034 recAck then recDone -> REQ->WAIT->IDLE; mispredict in WAIT -> no recReq.
REQ-035 rst=0 during REQ -> recReq=0 immediately, FSM IDLE after release.
